// File: rtl/ghash_pkg.sv
// ghash_pkg: shared types, widths and helpers for the GHASH accumulator
package ghash_pkg;
  localparam int BLK_W = 128;
  localparam int LEN_W = 64;
  localparam logic [0:BLK_W-1] R_POLY = {8'b1110_0001, 120'd0};
  typedef enum logic [1:0] {IDLE, ACCEPT, LEN, DONE} state_t;
  function automatic logic [0:BLK_W-1] byte_mask(input logic [4:0] cnt);
    byte_mask = '0;
    for (int i = 0; i < BLK_W / 8; i++) byte_mask[8*i +: 8] = (5'(i) < cnt) ? 8'hff : 8'h00;
  endfunction
endpackage

// File: rtl/gfmul.sv
// gfmul: combinational GF(2^128) multiply in GCM bit order (index 0 = x^0)
module gfmul
  import ghash_pkg::*;
(
  input  logic [0:BLK_W-1] a,
  input  logic [0:BLK_W-1] b,
  input  logic [0:BLK_W-1] r,
  output logic [0:BLK_W-1] z
);
  logic [0:BLK_W-1] v;
  always_comb begin
    z = '0;
    v = b;
    for (int i = 0; i < BLK_W; i++) begin
      z = a[i] ? z ^ v : z;
      v = v[BLK_W-1] ? (v >> 1) ^ r : v >> 1;
    end
  end
endmodule

// File: rtl/ghash_accum.sv
// ghash_accum: GHASH accumulation over AAD/ciphertext blocks plus the length block
module ghash_accum
  import ghash_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [0:BLK_W-1] iHashkey,
  input  logic             iValid,
  output logic             oReady,
  input  logic [0:BLK_W-1] iData,
  input  logic [4:0]       iByteCnt,
  input  logic             iType,
  input  logic             iLast,
  output logic [0:BLK_W-1] oHash,
  output logic             oHashValid,
  output logic             oBusy,
  output logic             oError
);
  state_t state;
  logic [0:BLK_W-1] y, h, gf_in, gf_out;
  logic [LEN_W-1:0] len_a, len_c, len_add;
  logic [4:0] cnt;
  logic seen_ct, err, bad;
  assign cnt = iByteCnt > 5'd16 ? 5'd16 : iByteCnt;
  assign len_add = {{(LEN_W-8){1'b0}}, cnt, 3'b000};
  assign bad = !iType && seen_ct;
  // one multiplier shared between data blocks and the trailing length block
  assign gf_in = (state == LEN) ? y ^ {len_a, len_c} : y ^ (iData & byte_mask(cnt));
  gfmul u_gfmul (.a(gf_in), .b(h), .r(R_POLY), .z(gf_out));
  assign oReady = state == ACCEPT;
  assign oHashValid = state == DONE;
  assign oBusy = state != IDLE;
  assign oError = err;
  assign oHash = y;
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      y <= '0;
      h <= '0;
      len_a <= '0;
      len_c <= '0;
      seen_ct <= 1'b0;
      err <= 1'b0;
    end else if (iStart) begin
      state <= ACCEPT;
      y <= '0;
      h <= iHashkey;
      len_a <= '0;
      len_c <= '0;
      seen_ct <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        ACCEPT: if (iValid) begin
          if (bad) err <= 1'b1;
          else begin
            if (cnt != 5'd0) y <= gf_out;
            if (iType) begin
              len_c <= len_c + len_add;
              seen_ct <= 1'b1;
            end else len_a <= len_a + len_add;
          end
          if (iLast) state <= LEN;
        end
        LEN: begin
          y <= gf_out;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ghash_accum.sv
// tb_ghash_accum: directed scoreboard bench for ghash_accum
module tb_ghash_accum;
  import ghash_pkg::*;
  logic iClk = 1'b0, iRst, iStart, iValid, iType, iLast;
  logic [0:127] iHashkey, iData, oHash;
  logic [4:0] iByteCnt;
  logic oReady, oHashValid, oBusy, oError;
  int n_chk = 0, n_fail = 0;
  logic [127:0] sb[$];
  localparam logic [0:127] H1 = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
  localparam logic [0:127] H2 = 128'h73A23D80121DE2D5A850253FCF43120E;
  localparam logic [0:127] C1 = 128'h0388DACE60B6A392F328C2B971B2FE78;
  localparam logic [0:127] Y1 = 128'h5E2EC746917062882C85B0685353DEB7;
  localparam logic [0:127] F1 = 128'hF38CBB1AD69223DCC3457AE5B6B0F885;

  ghash_accum dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iHashkey(iHashkey),
    .iValid(iValid), .oReady(oReady), .iData(iData), .iByteCnt(iByteCnt),
    .iType(iType), .iLast(iLast), .oHash(oHash), .oHashValid(oHashValid),
    .oBusy(oBusy), .oError(oError)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic start_msg(input logic [0:127] hk);
    iStart = 1'b1;
    iHashkey = hk;
    @(posedge iClk); #1;
    iStart = 1'b0;
    iHashkey = '1;
    chk1("start_ready", oReady, 1'b1);
    chk1("start_busy", oBusy, 1'b1);
    chk1("start_err", oError, 1'b0);
    chk("start_hash", oHash, '0);
  endtask

  task automatic blk(input logic [0:127] d, input logic [4:0] n, input logic t, input logic l, input logic [127:0] exp);
    chk1("blk_ready", oReady, 1'b1);
    iValid = 1'b1;
    iData = d;
    iByteCnt = n;
    iType = t;
    iLast = l;
    sb.push_back(exp);
    @(posedge iClk); #1;
    iValid = 1'b0;
    iLast = 1'b0;
    chk("blk_y", oHash, sb.pop_front());
  endtask

  task automatic finish_msg(input logic [127:0] f, input bit chk_hash, input bit hold);
    iValid = hold;
    iData = '1;
    iByteCnt = 5'd16;
    iType = 1'b1;
    chk1("len_ready", oReady, 1'b0);
    chk1("len_hv", oHashValid, 1'b0);
    chk1("len_busy", oBusy, 1'b1);
    @(posedge iClk); #1;
    chk1("done_hv", oHashValid, 1'b1);
    chk1("done_ready", oReady, 1'b0);
    if (chk_hash) chk("final", oHash, f);
    @(posedge iClk); #1;
    iValid = 1'b0;
    chk1("idle_hv", oHashValid, 1'b0);
    chk1("idle_busy", oBusy, 1'b0);
    chk1("idle_ready", oReady, 1'b0);
    if (chk_hash) chk("idle_hold", oHash, f);
  endtask

  initial begin
    iRst = 1'b1;
    iStart = 1'b0;
    iValid = 1'b0;
    iType = 1'b0;
    iLast = 1'b0;
    iHashkey = '0;
    iData = '0;
    iByteCnt = '0;
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    chk("rst_hash", oHash, '0);
    chk1("rst_ready", oReady, 1'b0);
    chk1("rst_busy", oBusy, 1'b0);
    chk1("rst_err", oError, 1'b0);
    chk1("rst_hv", oHashValid, 1'b0);
    // empty message
    start_msg(H1);
    blk('1, 5'd0, 1'b0, 1'b1, '0);
    finish_msg('0, 1'b1, 1'b0);
    // single ciphertext block, input valid held through LEN/DONE
    start_msg(H1);
    blk(C1, 5'd16, 1'b1, 1'b1, Y1);
    finish_msg(F1, 1'b1, 1'b1);
    // partial AAD and multiple blocks
    start_msg(H2);
    blk(128'hD609B1F056637A0D46DF998D88E52E00, 5'd16, 1'b0, 1'b0, 128'h9CABBD91899C1413AA7AD629C1DF12CD);
    blk({96'hB2C2846512153524C0895E81, 32'hFFFFFFFF}, 5'd12, 1'b0, 1'b0, 128'hB99ABF6BDBD18B8E148F8030F0686F28);
    blk(128'h701AFA1CC039C0D765128A665DAB6924, 5'd16, 1'b1, 1'b0, 128'h8B5BD74B9A65A459150392C3872BCE7F);
    blk(128'h3899BF7318CCDC81C9931DA17FBE8EDD, 5'd16, 1'b1, 1'b0, 128'h934E9D58C59230EE652675D0FF4FB255);
    blk(128'h7D17CB8B4C26FC81E3284F2B7FBA713D, 5'd16, 1'b1, 1'b0, 128'h4738D208B10FAFF24D6DFBDDC916DC44);
    chk("len_a", 128'(dut.len_a), 128'd224);
    chk1("no_err", oError, 1'b0);
    // AAD after ciphertext is an ordering error
    blk(128'h00112233445566778899AABBCCDDEEFF, 5'd16, 1'b0, 1'b0, 128'h4738D208B10FAFF24D6DFBDDC916DC44);
    chk1("ord_err", oError, 1'b1);
    chk("ord_len_a", 128'(dut.len_a), 128'd224);
    blk(128'hFFEEDDCCBBAA99887766554433221100, 5'd16, 1'b0, 1'b1, 128'h4738D208B10FAFF24D6DFBDDC916DC44);
    finish_msg('0, 1'b0, 1'b0);
    chk1("err_sticky", oError, 1'b1);
    // abort with simultaneous handshake; byte count above 16 clamps
    start_msg(H1);
    blk(C1, 5'd20, 1'b1, 1'b0, Y1);
    chk("len_c_clamp", 128'(dut.len_c), 128'd128);
    iStart = 1'b1;
    iHashkey = H1;
    iValid = 1'b1;
    iData = C1;
    iByteCnt = 5'd16;
    iType = 1'b1;
    sb.push_back('0);
    @(posedge iClk); #1;
    iStart = 1'b0;
    iValid = 1'b0;
    chk("abort_y", oHash, sb.pop_front());
    chk("abort_len_c", 128'(dut.len_c), '0);
    chk1("abort_ready", oReady, 1'b1);
    // reset mid-message
    blk(C1, 5'd16, 1'b1, 1'b0, Y1);
    iRst = 1'b1;
    iValid = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    iValid = 1'b0;
    chk("mrst_hash", oHash, '0);
    chk1("mrst_ready", oReady, 1'b0);
    chk1("mrst_busy", oBusy, 1'b0);
    chk1("mrst_err", oError, 1'b0);
    chk1("mrst_hv", oHashValid, 1'b0);
    chk("mrst_state", 128'(dut.state), 128'(IDLE));
    start_msg(H1);
    blk(C1, 5'd16, 1'b1, 1'b1, Y1);
    finish_msg(F1, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
